// File: rtl/nco_pkg.sv
// Shared constants, state type and quarter-sine table generator for the sin/cos NCO.
package nco_pkg;

    localparam int ADDR_W        = 11;
    localparam int ROM_AW        = 9;
    localparam int MAG_W         = 8;
    localparam int STEP_W        = 12;
    localparam int ROM_DEPTH     = 512;
    localparam int FRAME_LEN_DEF = 2048;

    // Fixed-point constants for the table generator (Q30).
    localparam longint Q30_ONE = 64'sd1073741824;
    localparam longint PI_Q30  = 64'sd3373259426;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } nco_state_e;

    // Builds entry i = round(255*sin(pi*(2i+1)/2048)) for i in 0..511 using an
    // integer Taylor series, so the table is fixed at elaboration time.
    function automatic logic [ROM_DEPTH*MAG_W-1:0] build_quarter_sine();
        logic [ROM_DEPTH*MAG_W-1:0] tbl;
        longint x;
        longint x2;
        longint term;
        longint acc;
        longint mag;
        tbl = '0;
        for (int i = 0; i < ROM_DEPTH; i++) begin
            x    = (PI_Q30 * longint'(2 * i + 1)) / 64'sd2048;
            x2   = (x * x) / Q30_ONE;
            term = x;
            acc  = x;
            for (int k = 1; k <= 7; k++) begin
                term = -((term * x2) / Q30_ONE) / longint'((2 * k) * (2 * k + 1));
                acc  = acc + term;
            end
            mag = (acc * 64'sd255 + Q30_ONE / 64'sd2) / Q30_ONE;
            tbl[i*MAG_W +: MAG_W] = mag[MAG_W-1:0];
        end
        return tbl;
    endfunction

endpackage

// File: rtl/nco_quarter_rom.sv
// Quarter-wave sine ROM, 512 x 8, two read ports with registered addresses
// (synchronous read): data follows the address captured on the last load.
module nco_quarter_rom
    import nco_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ROM_AW-1:0] addr_a,
    input  logic [ROM_AW-1:0] addr_b,
    output logic [MAG_W-1:0]  data_a,
    output logic [MAG_W-1:0]  data_b
);

    localparam logic [ROM_DEPTH*MAG_W-1:0] ROM_BITS = build_quarter_sine();

    logic [ROM_AW-1:0] addr_a_r;
    logic [ROM_AW-1:0] addr_b_r;

    // Capture both read addresses when a new sample is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_a_r <= '0;
            addr_b_r <= '0;
        end else if (load) begin
            addr_a_r <= addr_a;
            addr_b_r <= addr_b;
        end
    end

    // Table lookup from the registered addresses.
    always_comb begin
        data_a = ROM_BITS[int'(addr_a_r)*MAG_W +: MAG_W];
        data_b = ROM_BITS[int'(addr_b_r)*MAG_W +: MAG_W];
    end

endmodule

// File: rtl/sin_cos_nco.sv
// Sample-strobed sin/cos NCO with frame-aligned step updates and a 2-stage
// quarter-wave ROM pipeline. Optional macro NCO_FRAME_PHASE_RESET_EN restarts
// the phase at 0 on every frame-boundary sample.
module sin_cos_nco
    import nco_pkg::*;
#(
    parameter int PHASE_W   = 15,
    parameter int OUT_W     = 9,
    parameter int FRAME_LEN = FRAME_LEN_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cfg_wr,
    input  logic [7:0]       step_int,
    input  logic [3:0]       step_frac,
    output logic [OUT_W-1:0] sin,
    output logic [OUT_W-1:0] cos,
    output logic             valid,
    output logic             frame_start,
    output logic             frame_end,
    output logic             running
);

    localparam int CNT_W = $clog2(FRAME_LEN);

    nco_state_e         state_r, state_nxt_s;
    logic [PHASE_W-1:0] phase_r, phase_base_s;
    logic [STEP_W-1:0]  act_step_r, pend_step_r, step_eff_s, cfg_step_s;
    logic               pend_flag_r;
    logic [CNT_W-1:0]   frame_cnt_r;
    logic               accept_s, boundary_s, load_pend_s;
    logic [ADDR_W-1:0]  addr_s;
    logic [ROM_AW-1:0]  sin_addr_s, cos_addr_s;
    logic               v1_r, sign_sin_r, sign_cos_r, fs1_r, fe1_r;
    logic [MAG_W-1:0]   sin_mag_s, cos_mag_s;
    logic [OUT_W-1:0]   sin_ext_s, cos_ext_s, sin_val_s, cos_val_s;

    // IDLE waits for the first step write; RUN is left only through reset.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (cfg_wr) state_nxt_s = RUN;
                else        state_nxt_s = IDLE;
            end
            RUN:     state_nxt_s = RUN;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Sample acceptance, step selection and ROM address folding for this en.
    always_comb begin
        cfg_step_s  = {step_int, step_frac};
        accept_s    = (state_r == RUN) && en;
        boundary_s  = accept_s && (frame_cnt_r == CNT_W'(0));
        load_pend_s = boundary_s && pend_flag_r;
        if (load_pend_s) step_eff_s = pend_step_r;
        else             step_eff_s = act_step_r;
`ifdef NCO_FRAME_PHASE_RESET_EN
        if (boundary_s)  phase_base_s = '0;
        else             phase_base_s = phase_r;
`else
        phase_base_s = phase_r;
`endif
        addr_s = phase_base_s[PHASE_W-1 -: ADDR_W];
        if (addr_s[9]) begin
            sin_addr_s = ~addr_s[8:0];
            cos_addr_s = addr_s[8:0];
        end else begin
            sin_addr_s = addr_s[8:0];
            cos_addr_s = ~addr_s[8:0];
        end
    end

    // Stage-2 sign application; negating a zero magnitude leaves zero.
    always_comb begin
        sin_ext_s = {{(OUT_W-MAG_W){1'b0}}, sin_mag_s};
        cos_ext_s = {{(OUT_W-MAG_W){1'b0}}, cos_mag_s};
        if (sign_sin_r) sin_val_s = OUT_W'(0) - sin_ext_s;
        else            sin_val_s = sin_ext_s;
        if (sign_cos_r) cos_val_s = OUT_W'(0) - cos_ext_s;
        else            cos_val_s = cos_ext_s;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= IDLE;
        else        state_r <= state_nxt_s;
    end

    // Phase accumulator, frame counter and active/pending step bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_r     <= '0;
            frame_cnt_r <= '0;
            act_step_r  <= '0;
            pend_step_r <= '0;
            pend_flag_r <= 1'b0;
        end else if (state_r == IDLE) begin
            if (cfg_wr) begin
                act_step_r  <= cfg_step_s;
                phase_r     <= '0;
                frame_cnt_r <= '0;
            end
        end else begin
            if (accept_s) begin
                phase_r     <= phase_base_s + PHASE_W'(step_eff_s);
                frame_cnt_r <= frame_cnt_r + CNT_W'(1);
                if (load_pend_s) act_step_r <= pend_step_r;
            end
            // A write on the boundary sample queues behind the value it displaces.
            if (cfg_wr) begin
                pend_step_r <= cfg_step_s;
                pend_flag_r <= 1'b1;
            end else if (load_pend_s) begin
                pend_flag_r <= 1'b0;
            end
        end
    end

    // Stage 1: signs and frame markers of the accepted sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_r       <= 1'b0;
            sign_sin_r <= 1'b0;
            sign_cos_r <= 1'b0;
            fs1_r      <= 1'b0;
            fe1_r      <= 1'b0;
        end else begin
            v1_r <= accept_s;
            if (accept_s) begin
                sign_sin_r <= addr_s[10];
                sign_cos_r <= addr_s[10] ^ addr_s[9];
                fs1_r      <= (frame_cnt_r == CNT_W'(0));
                fe1_r      <= (frame_cnt_r == CNT_W'(FRAME_LEN - 1));
            end
        end
    end

    nco_quarter_rom u_rom (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (accept_s),
        .addr_a (sin_addr_s),
        .addr_b (cos_addr_s),
        .data_a (sin_mag_s),
        .data_b (cos_mag_s)
    );

    // Stage 2: registered outputs; samples hold between valid pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sin         <= '0;
            cos         <= '0;
            valid       <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            running     <= 1'b0;
        end else begin
            valid       <= v1_r;
            frame_start <= v1_r & fs1_r;
            frame_end   <= v1_r & fe1_r;
            running     <= (state_nxt_s == RUN);
            if (v1_r) begin
                sin <= sin_val_s;
                cos <= cos_val_s;
            end
        end
    end

endmodule

// File: tb/tb_sin_cos_nco.sv
// Scoreboard bench for sin_cos_nco: stimulus pushes expected samples, a
// monitor pops and compares whenever valid is high.
module tb_sin_cos_nco;

    localparam logic [8:0] ZER = 9'h000;
    localparam logic [8:0] POS = 9'h0FF;
    localparam logic [8:0] NEG = 9'h101;

    logic       clk = 1'b0;
    logic       rst_n, en, cfg_wr;
    logic [7:0] step_int;
    logic [3:0] step_frac;
    logic [8:0] sin, cos;
    logic       valid, frame_start, frame_end, running;

    sin_cos_nco #(.PHASE_W(15), .OUT_W(9), .FRAME_LEN(2048)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .cfg_wr(cfg_wr),
        .step_int(step_int), .step_frac(step_frac),
        .sin(sin), .cos(cos), .valid(valid),
        .frame_start(frame_start), .frame_end(frame_end), .running(running)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         idx;
        int         issue;
        bit         has_val;
        logic [8:0] es;
        logic [8:0] ec;
        bit         efs;
        bit         efe;
    } exp_t;

    exp_t       sb[$];
    int         n_run  = 0;
    int         n_fail = 0;
    int         cyc    = 0;
    int         smp    = 0;
    logic [8:0] chk_sin[int];
    logic [8:0] chk_cos[int];
    int         cfg_i[int];
    int         cfg_f[int];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: every valid must match the oldest outstanding sample.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (valid === 1'b1) begin
                if (sb.size() == 0) begin
                    n_run++;
                    n_fail++;
                    $display("FAIL unexpected_valid: valid=1 sin=%h cos=%h, required no output", sin, cos);
                end else begin
                    e = sb.pop_front();
                    n_run++;
                    if ((cyc - e.issue) != 2 || frame_start !== e.efs || frame_end !== e.efe) begin
                        n_fail++;
                        $display("FAIL timing_flags sample %0d: latency=%0d fs=%b fe=%b, required latency=2 fs=%b fe=%b",
                                 e.idx, cyc - e.issue, frame_start, frame_end, e.efs, e.efe);
                    end
                    if (e.has_val) begin
                        n_run++;
                        if (sin !== e.es || cos !== e.ec) begin
                            n_fail++;
                            $display("FAIL value sample %0d: sin=%h cos=%h, required sin=%h cos=%h",
                                     e.idx, sin, cos, e.es, e.ec);
                        end
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_run++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        en     = 1'b0;
        cfg_wr = 1'b0;
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic cfg_idle(input logic [7:0] si, input logic [3:0] sf);
        @(negedge clk);
        cfg_wr    = 1'b1;
        step_int  = si;
        step_frac = sf;
        @(negedge clk);
        cfg_wr = 1'b0;
    endtask

    task automatic add_chk(input int idx, input logic [8:0] s, input logic [8:0] c);
        chk_sin[idx] = s;
        chk_cos[idx] = c;
    endtask

    task automatic clear_tables();
        chk_sin.delete();
        chk_cos.delete();
        cfg_i.delete();
        cfg_f.delete();
        smp = 0;
    endtask

    // Issues n back-to-back en strobes, with cfg_wr on the listed sample indices.
    task automatic run_en(input int n);
        for (int s = 0; s < n; s++) begin
            exp_t e;
            @(negedge clk);
            en = 1'b1;
            if (cfg_i.exists(smp)) begin
                cfg_wr    = 1'b1;
                step_int  = 8'(cfg_i[smp]);
                step_frac = 4'(cfg_f[smp]);
            end else begin
                cfg_wr = 1'b0;
            end
            e.idx     = smp;
            e.issue   = cyc;
            e.efs     = ((smp % 2048) == 0);
            e.efe     = ((smp % 2048) == 2047);
            e.has_val = chk_sin.exists(smp);
            e.es      = e.has_val ? chk_sin[smp] : ZER;
            e.ec      = e.has_val ? chk_cos[smp] : ZER;
            sb.push_back(e);
            smp++;
        end
        @(negedge clk);
        en     = 1'b0;
        cfg_wr = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        en        = 1'b0;
        cfg_wr    = 1'b0;
        step_int  = 8'd0;
        step_frac = 4'd0;
        do_reset();

        // Reset state.
        @(negedge clk);
        check("reset_outputs", {14'd0, sin, cos, valid, frame_start, frame_end, running}, 32'd0);

        // en in IDLE is ignored.
        @(negedge clk);
        en = 1'b1;
        repeat (10) @(negedge clk);
        en = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_running", {31'd0, running}, 32'd0);

        // Step 1.0, then 2.0 pending from sample 100, then 3.0 at 3000 and a
        // write of 1.0 on the boundary sample 4096 that must wait a frame.
        clear_tables();
        add_chk(0,    ZER, POS);
        add_chk(512,  POS, ZER);
        add_chk(1024, ZER, NEG);
        add_chk(1536, NEG, ZER);
        add_chk(2048, ZER, POS);
        add_chk(2304, POS, ZER);
        add_chk(2560, ZER, NEG);
        add_chk(2816, NEG, ZER);
        add_chk(4096, ZER, POS);
        add_chk(4608, NEG, ZER);
        add_chk(5632, POS, ZER);
        add_chk(6144, ZER, POS);
        add_chk(6656, POS, ZER);
        add_chk(7168, ZER, NEG);
        cfg_i[100]  = 2; cfg_f[100]  = 0;
        cfg_i[3000] = 3; cfg_f[3000] = 0;
        cfg_i[4096] = 1; cfg_f[4096] = 0;
        cfg_idle(8'd1, 4'd0);
        check("run_after_cfg", {31'd0, running}, 32'd1);
        run_en(7169);
        repeat (4) @(negedge clk);
        check("drain_long", sb.size(), 32'd0);

        // Reset in the middle of a frame.
        do_reset();
        clear_tables();
        add_chk(0, ZER, POS);
        cfg_idle(8'd1, 4'd0);
        run_en(700);
        en = 1'b1;
        #1;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("midreset_outputs", {14'd0, sin, cos, valid, frame_start, frame_end, running}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        en = 1'b0;
        repeat (4) @(negedge clk);
        check("post_reset_running", {31'd0, running}, 32'd0);
        check("post_reset_valid", {31'd0, valid}, 32'd0);
        clear_tables();
        add_chk(0, ZER, POS);
        cfg_idle(8'd1, 4'd0);
        run_en(1);
        repeat (4) @(negedge clk);

        // Fractional step 0.5: address advances once every two samples.
        do_reset();
        clear_tables();
        add_chk(0,    ZER, POS);
        add_chk(1,    ZER, POS);
        add_chk(1024, POS, ZER);
        cfg_idle(8'd0, 4'd8);
        run_en(1025);
        repeat (4) @(negedge clk);
        check("drain_final", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/sin_cos_nco.md
SIN_COS_NCO -- requirements
Module: sin_cos_nco

Interface
REQ-001 SHALL have parameter PHASE_W, default 15, meaning the phase accumulator width.
REQ-002 SHALL have parameter OUT_W, default 9, meaning the signed sin/cos output width.
REQ-003 SHALL have parameter FRAME_LEN, default 2048, meaning the samples per approximation frame (power of two).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port en, input, 1 bit: ADC sample strobe, one sample per high cycle.
REQ-007 SHALL have port cfg_wr, input, 1 bit: single-cycle step-write strobe.
REQ-008 SHALL have port step_int, input, 8 bits: integer frequency multiple.
REQ-009 SHALL have port step_frac, input, 4 bits: fractional step.
REQ-010 SHALL have ports sin and cos, output, OUT_W bits each: two's-complement samples.
REQ-011 SHALL have port valid, output, 1 bit: sin/cos valid, exactly 2 cycles after the accepted en.
REQ-012 SHALL have port frame_start, output, 1 bit: high with valid on frame sample 0.
REQ-013 SHALL have port frame_end, output, 1 bit: high with valid on frame sample FRAME_LEN-1.
REQ-014 SHALL have port running, output, 1 bit: high in state RUN.

Function
REQ-015 SHALL implement states IDLE and RUN; IDLE->RUN on cfg_wr, with no other transitions except reset.
REQ-016 In IDLE, en SHALL be ignored, and valid, frame_start and frame_end SHALL stay 0.
REQ-017 On the IDLE cfg_wr, active step SHALL be set to {step_int,step_frac}, with phase=0 and frame counter=0.
REQ-018 In RUN, each en SHALL add the active step to the phase, modulo 2^PHASE_W with silent wrap-around.
REQ-019 Table address a[10:0] SHALL equal phase[PHASE_W-1:PHASE_W-11], taken before that en's increment.
REQ-020 Stage 1 SHALL register the ROM addresses and signs:
- sin_addr = a[9] ? ~a[8:0] : a[8:0]
- cos_addr = a[9] ? a[8:0] : ~a[8:0]
- sign_sin = a[10]
- sign_cos = a[10]^a[9]
REQ-021 Stage 2 SHALL register the ROM magnitude (0..255), zero-extended to OUT_W and negated when its sign is set, so that 0 stays 0.
REQ-022 SHALL hold sin and cos stable between valid pulses.
REQ-023 The frame counter SHALL count accepted en mod FRAME_LEN.
REQ-024 frame_start and frame_end SHALL be delayed to align with valid.
REQ-025 cfg_wr in RUN SHALL load a pending step and set a pending flag without changing output.
REQ-026 A pending step SHALL become active on the first en of the next frame (counter==0), and the flag SHALL clear.
REQ-027 If cfg_wr coincides with the boundary en, the old pending value SHALL apply and the new value SHALL wait for the following boundary.
REQ-028 Back-to-back en (every cycle) SHALL be supported with no bubbles.

Reset
REQ-029 rst_n low SHALL asynchronously force:
- state IDLE
- phase, active step, pending step and frame counter 0
- pending flag 0
- pipeline registers 0
- sin = cos = 0
- valid = frame_start = frame_end = running = 0
REQ-030 Reset mid-frame SHALL discard in-flight samples, and no valid SHALL appear after release until cfg_wr plus en.

Configuration
REQ-031 Macro NCO_FRAME_PHASE_RESET_EN, when defined, SHALL clear phase to 0 on every frame-boundary en, so each frame starts at address 0.
REQ-032 Without NCO_FRAME_PHASE_RESET_EN, phase SHALL be continuous across frames.

Structure
REQ-033 Shared package nco_pkg SHALL hold:
- ADDR_W=11, ROM_AW=9, MAG_W=8
- FRAME_LEN default
- state enum {IDLE,RUN}
REQ-034 Sub-module nco_quarter_rom SHALL be a registered 512x8 dual-port ROM, entry i = round(255*sin(2*pi*(i+0.5)/2048)), giving ROM[0]=0 and ROM[511]=255.

Verification
REQ-035 Reset; cfg_wr with step 1.0; one en -> valid 2 cycles later with sin=0, cos=+255, frame_start=1.
REQ-036 Step 1.0; en held for 1025 cycles:
- sample 512 -> sin=+255, cos=0
- sample 1024 -> sin=0, cos=-255 (9'h101)
REQ-037 2048 continuous en -> frame_end on sample 2047, frame_start on sample 2048 (next frame), no bubbles.
REQ-038 In RUN, cfg_wr at sample 100 with step 2.0 -> step unchanged until sample 2048, then address advances 2 per en.
- With NCO_FRAME_PHASE_RESET_EN: sample 2048 gives sin=0, cos=+255.
REQ-039 rst_n low at sample 700 of a frame -> all outputs 0 immediately, running=0, and en ignored until the next cfg_wr.
